// File: rtl/cpu_pkg.sv
// Shared types and defaults for the single-cycle core and its run controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  // Run controller sequencing states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } run_state_t;

  // PC value at which a program is considered finished.
  localparam int HALT_PC_DEF = 128;

  // Run-cycle limit before a program is declared runaway.
  localparam int WDOG_DEF = 4000;

endpackage

// File: rtl/run_counter.sv
// Up-counter with synchronous clear, count enable and a look-ahead terminal-count flag.
// Latency: count updates on the edge after en_i/clr_i; tc_o is combinational from the count.
// Backpressure: none; en_i stalls the count, clr_i has priority over en_i.
module run_counter #(
  parameter int W     = 16,
  parameter int LIMIT = 4000
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W:0] LIMIT_W = (W+1)'(LIMIT);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step by one when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  // High when the next counting edge lands exactly on LIMIT; the extra bit keeps
  // the compare exact even when LIMIT sits at the top of the count range.
  assign tc_o  = (({1'b0, cnt_q} + (W+1)'(1)) == LIMIT_W);

endmodule

// File: rtl/run_ctrl.sv
// Run controller: start/done handshake, optional data-memory zero-fill, core release/stall, halt and watchdog.
// Latency: start edge -> CLEAR (one write per cycle) or straight to RUN; done rises the edge after halt/limit.
// Backpressure: req is a level 4-phase handshake; dropping req in CLEAR/RUN aborts to IDLE on the next edge.
module run_ctrl
  import cpu_pkg::*;
#(
  parameter int D       = 12,
  parameter int HALT_PC = HALT_PC_DEF,
  parameter int CLR_LO  = 0,
  parameter int CLR_HI  = 255,
  parameter int CW      = 16,
  parameter int WDOG    = WDOG_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          clr_en,
  input  logic [D-1:0]  prog_ctr,
  output logic          core_rst,
  output logic          core_en,
  output logic          mem_sel,
  output logic          mem_wr_en,
  output logic [7:0]    mem_addr,
  output logic [7:0]    mem_dat,
  output logic          done,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam logic [D-1:0] HALT_V = D'(HALT_PC);
  localparam logic [7:0]   LO_V   = 8'(CLR_LO);
  localparam logic [7:0]   HI_V   = 8'(CLR_HI);

  run_state_t state_q, state_d;
  logic [7:0] addr_q, addr_d;
  logic       timeout_q, timeout_d;
  logic       core_rst_q, mem_sel_q, done_q, run_q;
  logic       halt_w, count_w, start_w, wdog_tc_w;

  // run_q mirrors state==RUN as a flop so core_en only adds the halt compare.
  assign halt_w  = (prog_ctr == HALT_V);
  assign core_en = run_q & ~halt_w;
  assign count_w = core_en;
  assign start_w = (state_q == IDLE) & req;

  // Executed-cycle counter doubling as the watchdog.
  run_counter #(
    .W     (CW),
    .LIMIT (WDOG)
  ) u_cycles (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (start_w),
    .en_i   (count_w),
    .cnt_o  (cycles),
    .tc_o   (wdog_tc_w)
  );

  // Next state and timeout flag; abort (req low) outranks halt and watchdog.
  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d   = clr_en ? CLEAR : RUN;
          timeout_d = 1'b0;
        end
      end
      CLEAR: begin
        if (!req) begin
          state_d = IDLE;
        end else if (addr_q == HI_V) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!req) begin
          state_d = IDLE;
        end else if (halt_w) begin
          state_d = DONE;
        end else if (count_w && wdog_tc_w) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Fill address: loads CLR_LO on entry to CLEAR, steps while in CLEAR, parks at 0
  // otherwise, so it never wraps past CLR_HI.
  always_comb begin
    addr_d = 8'h00;
    if (state_d == CLEAR) begin
      addr_d = (state_q == CLEAR) ? (addr_q + 8'd1) : LO_V;
    end
  end

  // State, fill address and registered Moore outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 8'h00;
      timeout_q  <= 1'b0;
      core_rst_q <= 1'b1;
      mem_sel_q  <= 1'b0;
      done_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timeout_q  <= timeout_d;
      core_rst_q <= (state_d == IDLE) || (state_d == CLEAR);
      mem_sel_q  <= (state_d == CLEAR);
      done_q     <= (state_d == DONE);
      run_q      <= (state_d == RUN);
    end
  end

  assign core_rst  = core_rst_q;
  assign mem_sel   = mem_sel_q;
  assign mem_wr_en = mem_sel_q;
  assign mem_addr  = addr_q;
  assign mem_dat   = 8'h00;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_run_ctrl.sv
// Randomized scoreboard bench for run_ctrl: driver pushes expected writes, per-run-cycle core_en and run results.
// Latency: n/a.
// Backpressure: n/a.
module tb_run_ctrl;

  localparam int D    = 12;
  localparam int HALT = 128;
  localparam int LO   = 0;
  localparam int HI   = 3;
  localparam int CW   = 16;
  localparam int WD   = 20;

  logic          clk = 1'b0;
  logic          reset, req, clr_en;
  logic [D-1:0]  prog_ctr;
  logic          core_rst, core_en, mem_sel, mem_wr_en, done, timeout;
  logic [7:0]    mem_addr, mem_dat;
  logic [CW-1:0] cycles;

  run_ctrl #(
    .D(D), .HALT_PC(HALT), .CLR_LO(LO), .CLR_HI(HI), .CW(CW), .WDOG(WD)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .clr_en(clr_en), .prog_ctr(prog_ctr),
    .core_rst(core_rst), .core_en(core_en), .mem_sel(mem_sel), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_dat(mem_dat), .done(done), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit aborted;
    int cyc;
    bit tmo;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  int   wr_q[$];
  bit   en_q[$];
  res_t res_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT output with nothing expected (t=%0t)", name, $time);
  endtask

  function automatic res_t mk_res(input bit ab, input int c, input bit t);
    res_t r;
    r.aborted = ab;
    r.cyc     = c;
    r.tmo     = t;
    return r;
  endfunction

  function automatic logic [D-1:0] rand_pc();
    logic [D-1:0] v;
    do v = D'($urandom_range(0, (1 << D) - 1)); while (v == D'(HALT));
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rst(input string tag);
    chk({tag, ".core_rst"}, core_rst, 1);
    chk({tag, ".core_en"}, core_en, 0);
    chk({tag, ".mem_sel"}, mem_sel, 0);
    chk({tag, ".mem_wr_en"}, mem_wr_en, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_dat"}, mem_dat, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".timeout"}, timeout, 0);
    chk({tag, ".cycles"}, cycles, 0);
  endtask

  // Raise req; the window is zero-filled first when ce is set. Returns in the first RUN cycle.
  task automatic start_run(input bit ce);
    clr_en = ce;
    req    = 1'b1;
    if (ce) for (int a = LO; a <= HI; a++) wr_q.push_back(a);
    tick();
    clr_en = 1'($urandom_range(0, 1));
    if (ce) repeat (HI - LO + 1) tick();
  endtask

  // Hold req in DONE for a while (no restart allowed), then release.
  task automatic release_done();
    repeat ($urandom_range(1, 4)) begin
      prog_ctr = rand_pc();
      tick();
    end
    req = 1'b0;
    tick();
    repeat (2) tick();
  endtask

  task automatic run_halt(input int k);
    res_q.push_back(mk_res(1'b0, k, 1'b0));
    for (int i = 0; i < k; i++) begin
      prog_ctr = rand_pc();
      en_q.push_back(1'b1);
      tick();
    end
    prog_ctr = D'(HALT);
    en_q.push_back(1'b0);
    tick();
    release_done();
  endtask

  task automatic run_wdog();
    res_q.push_back(mk_res(1'b0, WD, 1'b1));
    prog_ctr = rand_pc();
    for (int i = 0; i < WD; i++) begin
      en_q.push_back(1'b1);
      tick();
    end
    release_done();
  endtask

  task automatic run_abort(input int m);
    res_q.push_back(mk_res(1'b1, m, 1'b0));
    for (int i = 0; i < m; i++) begin
      prog_ctr = rand_pc();
      if (i == m - 1) req = 1'b0;
      en_q.push_back(1'b1);
      tick();
    end
    repeat (2) tick();
  endtask

  // Monitor: pops expectations whenever the DUT presents a write, a run cycle, or a run ending.
  initial begin
    bit pd, pr;
    res_t r;
    pd = 1'b0;
    pr = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        pd = 1'b0;
        pr = 1'b1;
        continue;
      end
      if (mem_sel) begin
        chk("wr_en", mem_wr_en, 1);
        chk("wr_dat", mem_dat, 0);
        if (wr_q.size() == 0) fail_now("wr_extra");
        else chk("wr_addr", mem_addr, wr_q.pop_front());
      end
      if (!core_rst && !done) begin
        if (en_q.size() == 0) fail_now("run_cycle_extra");
        else chk("core_en", core_en, en_q.pop_front());
      end
      if (done && !pd) begin
        if (res_q.size() == 0) fail_now("done_extra");
        else begin
          r = res_q.pop_front();
          chk("done_on_abort", r.aborted, 0);
          chk("done_cycles", cycles, r.cyc);
          chk("done_timeout", timeout, r.tmo);
          chk("done_core_en", core_en, 0);
        end
      end
      if (core_rst && !pr) begin
        if (pd) chk("done_drop", done, 0);
        else if (res_q.size() == 0) fail_now("abort_extra");
        else begin
          r = res_q.pop_front();
          chk("abort_expected", r.aborted, 1);
          chk("abort_cycles", cycles, r.cyc);
          chk("abort_done", done, 0);
          chk("abort_timeout", timeout, r.tmo);
        end
      end
      pd = done;
      pr = core_rst;
    end
  end

  initial begin
    reset    = 1'b0;
    req      = 1'b0;
    clr_en   = 1'b0;
    prog_ctr = '0;
    repeat (2) @(posedge clk);
    #1;
    check_rst("reset");
    reset = 1'b1;
    repeat (2) tick();

    // Directed cases from the test plan and boundaries.
    start_run(1'b1); run_halt(10);
    start_run(1'b0); run_halt(10);
    start_run(1'b0); run_wdog();
    start_run(1'b0); run_abort(7);
    start_run(1'b0); run_halt(WD - 1);
    start_run(1'b0); run_wdog();
    start_run(1'b0); run_halt(0);
    start_run(1'b1); run_abort(1);

    // Randomized runs.
    for (int n = 0; n < 25; n++) begin
      start_run(1'($urandom_range(0, 1)));
      case ($urandom_range(0, 2))
        0: run_halt($urandom_range(0, WD - 1));
        1: run_wdog();
        default: run_abort($urandom_range(1, WD - 1));
      endcase
    end

    // Asynchronous reset while the fill is presenting address 2.
    clr_en = 1'b1;
    req    = 1'b1;
    wr_q.push_back(0);
    wr_q.push_back(1);
    tick();
    repeat (2) tick();
    reset = 1'b0;
    #1;
    check_rst("reset_mid_clear");
    req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Asynchronous reset in the middle of a run clears the partial count.
    start_run(1'b0);
    for (int i = 0; i < 5; i++) begin
      prog_ctr = rand_pc();
      en_q.push_back(1'b1);
      tick();
    end
    reset = 1'b0;
    #1;
    check_rst("reset_mid_run");
    req = 1'b0;
    tick();
    reset = 1'b1;
    repeat (2) tick();

    // Recovery after reset.
    start_run(1'b1); run_halt(3);

    repeat (3) tick();
    chk("wr_q_left", wr_q.size(), 0);
    chk("en_q_left", en_q.size(), 0);
    chk("res_q_left", res_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
